// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared pulled-low tri-state bus.
// One registered one-hot grant at a time, separated by an all-released turnaround.
module tri_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           oe,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       preempt
);

    localparam int unsigned OW       = $clog2(N_REQ);
    localparam int unsigned HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int unsigned HW       = $clog2(HOLD_SAT + 1);
    localparam int unsigned TW       = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_TURN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    w_gnt_nxt;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       w_owner_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_preempt;
    logic                w_preempt_nxt;
    logic [OW-1:0]       r_rr_ptr;
    logic [OW-1:0]       w_rr_ptr_nxt;
    logic [HW-1:0]       r_hold_cnt;
    logic [HW-1:0]       w_hold_cnt_nxt;
    logic [TW-1:0]       r_turn_cnt;
    logic [TW-1:0]       w_turn_cnt_nxt;

    logic                w_found;
    logic [OW-1:0]       w_win;
    logic [OW-1:0]       w_cand;
    logic                w_others_waiting;
    logic                w_hold_limit;

    // Scan starts just after the last winner, so the winner drops to lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_cand = OW'((32'(r_rr_ptr) + i) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_others_waiting = |(req & ~r_gnt);
    assign w_hold_limit     = (MAX_HOLD != 0) && (r_hold_cnt == HW'(HOLD_SAT));

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_busy_nxt     = r_busy;
        w_preempt_nxt  = 1'b0;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_turn_cnt_nxt = r_turn_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt       = S_OWN;
                    w_gnt_nxt         = '0;
                    w_gnt_nxt[w_win]  = 1'b1;
                    w_owner_nxt       = w_win;
                    w_busy_nxt        = 1'b1;
                    w_rr_ptr_nxt      = w_win;
                    w_hold_cnt_nxt    = HW'(1);
                end
            end

            S_OWN: begin
                // A release wins over a preemption landing on the same edge.
                if (!req[r_owner]) begin
                    w_state_nxt    = S_TURN;
                    w_gnt_nxt      = '0;
                    w_busy_nxt     = 1'b0;
                    w_turn_cnt_nxt = TW'(1);
                end else if (w_hold_limit && w_others_waiting) begin
                    w_state_nxt    = S_TURN;
                    w_gnt_nxt      = '0;
                    w_busy_nxt     = 1'b0;
                    w_preempt_nxt  = 1'b1;
                    w_turn_cnt_nxt = TW'(1);
                end else if (r_hold_cnt != HW'(HOLD_SAT)) begin
                    w_hold_cnt_nxt = r_hold_cnt + HW'(1);
                end
            end

            S_TURN: begin
                if (r_turn_cnt == TW'(TURN_CYC)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt + TW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
            r_rr_ptr   <= OW'(N_REQ - 1);
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_busy     <= w_busy_nxt;
            r_preempt  <= w_preempt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign oe      = r_gnt;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: per-cycle expectations queued at drive time,
// popped and checked just after each rising edge.
module tb_tri_bus_arbiter;

    logic       clk;
    logic       rst1_n, rst3_n;
    logic [3:0] req1, gnt1, oe1;
    logic [3:0] req3, gnt3, oe3;
    logic [1:0] own1, own3;
    logic       busy1, pre1, busy3, pre3;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       pre;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sel3     = 1'b0;

    tri_bus_arbiter #(.N_REQ(4), .TURN_CYC(1), .MAX_HOLD(16)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .req(req1), .gnt(gnt1), .oe(oe1),
        .owner(own1), .busy(busy1), .preempt(pre1)
    );

    tri_bus_arbiter #(.N_REQ(4), .TURN_CYC(3), .MAX_HOLD(16)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .req(req3), .gnt(gnt3), .oe(oe3),
        .owner(own3), .busy(busy3), .preempt(pre3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] g, input logic p);
        exp_t e;
        e.tag   = tag;
        e.gnt   = g;
        e.busy  = (g != 4'b0000);
        e.pre   = p;
        e.owner = 2'd0;
        for (int k = 0; k < 4; k++) if (g[k]) e.owner = 2'(k);
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [3:0] g, o;
        logic [1:0] ow;
        logic       b, p;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e  = sb.pop_front();
        g  = sel3 ? gnt3  : gnt1;
        o  = sel3 ? oe3   : oe1;
        ow = sel3 ? own3  : own1;
        b  = sel3 ? busy3 : busy1;
        p  = sel3 ? pre3  : pre1;
        n_checks++;
        assert (g === e.gnt) else begin
            n_fail++;
            $error("FAIL %s gnt observed=%b expected=%b", e.tag, g, e.gnt);
        end
        n_checks++;
        assert (o === e.gnt) else begin
            n_fail++;
            $error("FAIL %s oe observed=%b expected=%b", e.tag, o, e.gnt);
        end
        n_checks++;
        assert (b === e.busy) else begin
            n_fail++;
            $error("FAIL %s busy observed=%b expected=%b", e.tag, b, e.busy);
        end
        n_checks++;
        assert (p === e.pre) else begin
            n_fail++;
            $error("FAIL %s preempt observed=%b expected=%b", e.tag, p, e.pre);
        end
        if (e.busy) begin
            n_checks++;
            assert (ow === e.owner) else begin
                n_fail++;
                $error("FAIL %s owner observed=%0d expected=%0d", e.tag, ow, e.owner);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] g, input logic p);
        push(tag, g, p);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        req1   = 4'b0000;
        req3   = 4'b0000;

        // Async reset clears outputs before any clock edge.
        #2;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        #1;
        push("reset_async", 4'b0000, 1'b0);
        check_now();
        cyc("reset_held", 4'b0000, 1'b0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        // Test 1: single request, one-edge latency.
        cyc("t1_idle", 4'b0000, 1'b0);
        req1 = 4'b0100;
        cyc("t1_grant", 4'b0100, 1'b0);
        cyc("t1_hold", 4'b0100, 1'b0);
        req1 = 4'b0000;
        cyc("t1_turn", 4'b0000, 1'b0);
        cyc("t1_idle2", 4'b0000, 1'b0);

        // Re-reset so the rotation starts at requester 0.
        #2;
        rst1_n = 1'b0;
        #1;
        push("rereset_async", 4'b0000, 1'b0);
        check_now();
        @(posedge clk);
        #1;
        rst1_n = 1'b1;

        // Test 2: all requesting, 16-cycle tenures, preempt pulses, rotation 0,1,2,3,0.
        req1 = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            logic [3:0] g;
            g = 4'b0001 << (r % 4);
            for (int c = 0; c < 16; c++) cyc("t2_own", g, 1'b0);
            if (r < 4) begin
                cyc("t2_preempt", 4'b0000, 1'b1);
                cyc("t2_gap", 4'b0000, 1'b0);
            end
        end
        req1 = 4'b0000;
        cyc("t2_release", 4'b0000, 1'b0);
        cyc("t2_idle", 4'b0000, 1'b0);

        // Test 3: lone requester keeps the bus indefinitely.
        req1 = 4'b0010;
        for (int c = 0; c < 100; c++) cyc("t3_lone", 4'b0010, 1'b0);
        req1 = 4'b0000;
        cyc("t3_turn", 4'b0000, 1'b0);
        cyc("t3_idle", 4'b0000, 1'b0);

        // Test 6: release on the MAX_HOLD cycle with another waiting is a plain release.
        req1 = 4'b0001;
        cyc("t6_grant", 4'b0001, 1'b0);
        req1 = 4'b0101;
        for (int c = 0; c < 15; c++) cyc("t6_own", 4'b0001, 1'b0);
        req1 = 4'b0100;
        cyc("t6_release", 4'b0000, 1'b0);
        cyc("t6_idle", 4'b0000, 1'b0);
        cyc("t6_next", 4'b0100, 1'b0);
        req1 = 4'b0000;
        cyc("t6_turn", 4'b0000, 1'b0);
        cyc("t6_idle2", 4'b0000, 1'b0);

        // Test 5: reset mid-ownership clears without a clock edge.
        req1 = 4'b1000;
        cyc("t5_grant", 4'b1000, 1'b0);
        cyc("t5_hold", 4'b1000, 1'b0);
        #2;
        rst1_n = 1'b0;
        #1;
        push("t5_async_clear", 4'b0000, 1'b0);
        check_now();
        req1 = 4'b1001;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        cyc("t5_after_reset", 4'b0001, 1'b0);
        req1 = 4'b0000;
        cyc("t5_turn", 4'b0000, 1'b0);

        // Test 4: TURN_CYC=3 gives three released cycles plus one idle cycle.
        sel3 = 1'b1;
        cyc("t4_idle", 4'b0000, 1'b0);
        req3 = 4'b0001;
        cyc("t4_grant", 4'b0001, 1'b0);
        req3 = 4'b0101;
        cyc("t4_hold", 4'b0001, 1'b0);
        req3 = 4'b0100;
        cyc("t4_turn1", 4'b0000, 1'b0);
        cyc("t4_turn2", 4'b0000, 1'b0);
        cyc("t4_turn3", 4'b0000, 1'b0);
        cyc("t4_idle2", 4'b0000, 1'b0);
        cyc("t4_next", 4'b0100, 1'b0);
        req3 = 4'b0000;
        cyc("t4_release", 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
